program_memory_loader: RTL
==========================

Name: program_memory_loader

Overview:
- Writer side of the instruction memory. Receives a byte stream (boot/debug link) and assembles big-endian 32-bit instruction words.
- Drives a synchronous write port into instruction memory at byte addresses BASE_ADDRESS, +4, +8, … so the memory's word index is Address>>2.
- Lets the processor be loaded at run time instead of only through a preloaded image file.

Parameters:
- MEMORY_DEPTH, 32, number of instruction words in the target memory; upper bound on the load length.
- DATA_WIDTH, 32, instruction word and address width; must be a multiple of 8. BYTES_PER_WORD = DATA_WIDTH/8.
- BASE_ADDRESS, 0, byte address of the first written word; must be word aligned.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- Start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR
- ByteIn  input  8  stream data byte
- ByteValid  input  1  ByteIn is valid
- ByteReady  output  1  loader accepts a byte this cycle; transfer occurs when ByteValid && ByteReady
- WriteEnable  output  1  one-cycle memory write strobe
- WriteAddress  output  DATA_WIDTH  byte address of the write
- WriteData  output  DATA_WIDTH  instruction word to write
- Busy  output  1  load in progress
- Done  output  1  sticky; load completed successfully
- Error  output  1  sticky; load aborted
- WordCount  output  DATA_WIDTH  number of words written so far in the current load

Behaviour:
- Reset: state IDLE. All outputs 0: ByteReady, WriteEnable, WriteAddress, WriteData, Busy, Done, Error, WordCount. Internal byte counter, address and word-length registers are cleared. Reset mid-load abandons the load with no further writes.
- Stream format: a header of BYTES_PER_WORD bytes giving the word count N (MSB first), then N words, each MSB first.
- State IDLE: ByteReady=0. Start moves to HEADER and sets Busy=1, clears Done, Error and WordCount, and sets the address to BASE_ADDRESS.
- State HEADER: ByteReady=1. Each accepted byte is shifted into the length register.
  - After the last header byte, the next state is chosen by N:
  - N > MEMORY_DEPTH -> ERROR.
  - N == 0 -> DONE (or CHECK when the checksum feature is compiled in).
  - Otherwise -> DATA.
- State DATA: ByteReady=1. Each accepted byte is shifted into the word assembly register (first byte lands in bits [DATA_WIDTH-1:DATA_WIDTH-8]). After the BYTES_PER_WORD-th byte -> WRITE.
- State WRITE: lasts exactly one cycle.
  - ByteReady=0, WriteEnable=1; WriteAddress and WriteData hold the current word.
  - On the following edge: address += 4, WordCount += 1.
  - Then -> DATA if WordCount+1 < N, else -> DONE (or CHECK).
- WriteAddress and WriteData keep their last values when WriteEnable=0.
- Throughput: at most one byte per cycle. A word costs BYTES_PER_WORD accept cycles plus 1 write cycle.
- State DONE: Busy=0, Done=1, ByteReady=0.
- State ERROR: Busy=0, Error=1, ByteReady=0, no writes.
- Start while in HEADER, DATA or WRITE is ignored.
- Start in DONE or ERROR begins a new load and clears Done/Error in the same edge.
- ByteValid while ByteReady=0: the byte is not consumed. The source must hold it.
- Address arithmetic wraps modulo 2^DATA_WIDTH. It cannot be reached when the length check passes with sane parameters.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined: after the N-th data word, state CHECK accepts BYTES_PER_WORD further bytes forming a checksum word.
  - The checksum is the XOR of the header word and all data words.
  - Match -> DONE; mismatch -> ERROR.
  - Words already written remain in memory.
- Undefined: no CHECK state. Loading ends at DONE after the last WRITE and no trailing bytes are consumed.

Decomposition:
- Shared package mips_loader_pkg holds:
  - the state encoding constants IDLE, HEADER, DATA, WRITE, CHECK, DONE, ERROR;
  - the word address stride 4;
  - BYTES_PER_WORD as a derived constant.
- One natural sub-module: loader_byte_assembler. It contains the shift register and byte counter, with word_ready out and a clear input. It is reused for the header, data and checksum words.
- The FSM and address/count logic stay in the top module.

Test Plan:
- Reset held 3 cycles with ByteValid=1 -> all outputs 0, ByteReady=0, no WriteEnable.
- Start, then bytes 00 00 00 02, 20 08 00 05, 01 09 50 20 streamed back-to-back:
  - WriteEnable pulses twice: (0x0, 0x20080005), then (0x4, 0x01095020);
  - ByteReady low exactly during each write cycle;
  - Done=1, WordCount=2, Busy=0.
- Header 00 00 00 21 with MEMORY_DEPTH=32 -> Error=1, Done=0, zero WriteEnable pulses, ByteReady=0 afterwards.
- Header 00 00 00 00 -> Done=1 one cycle after the last header byte (macro off), no writes.
- ByteValid toggled randomly during a 3-word load, plus a Start pulse mid-load -> data and addresses 0x0/0x4/0x8 identical to the back-to-back case; the mid-load Start is ignored.
- Reset asserted during the second word's bytes -> next cycle IDLE with outputs 0. A fresh 1-word load then writes address BASE_ADDRESS correctly.
- LOADER_CHECKSUM_EN: 1-word load 0x8C010004 with correct checksum 0x8C010005 -> Done; with 0x00000000 -> Error, and the word is still written once.

Source files
------------

// File: rtl/mips_loader_pkg.sv
// Shared definitions for the program memory loader.
// Contents:
//   loader_state_e  - loader FSM state encoding (IDLE..ERROR)
//   ADDR_STRIDE     - byte distance between consecutive instruction words
//   bytes_per_word  - bytes in a word of a given bit width
//   BYTES_PER_WORD  - bytes per word for the default 32-bit word
package mips_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } loader_state_e;

  localparam int unsigned ADDR_STRIDE        = 32'd4;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32'd32;

  function automatic int unsigned bytes_per_word(input int unsigned width);
    return width / 32'd8;
  endfunction

  localparam int unsigned BYTES_PER_WORD = bytes_per_word(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/program_memory_loader_if.sv
// Byte-stream and memory-write bundle of the program memory loader.
// Signals:
//   Start, ByteIn[7:0], ByteValid       - host -> loader (stream side)
//   ByteReady                           - loader -> host, byte accepted when ByteValid && ByteReady
//   WriteEnable, WriteAddress, WriteData - loader -> instruction memory write port
//   Busy, Done, Error, WordCount        - loader status
// Modports: master (host / stream source), slave (loader).
interface program_memory_loader_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  Start;
  logic [7:0]            ByteIn;
  logic                  ByteValid;
  logic                  ByteReady;
  logic                  WriteEnable;
  logic [DATA_WIDTH-1:0] WriteAddress;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  Busy;
  logic                  Done;
  logic                  Error;
  logic [DATA_WIDTH-1:0] WordCount;

  modport master (
    output Start, ByteIn, ByteValid,
    input  ByteReady, WriteEnable, WriteAddress, WriteData,
    input  Busy, Done, Error, WordCount
  );

  modport slave (
    input  Start, ByteIn, ByteValid,
    output ByteReady, WriteEnable, WriteAddress, WriteData,
    output Busy, Done, Error, WordCount
  );

endinterface

// File: rtl/loader_byte_assembler.sv
// Assembles DATA_WIDTH/8 stream bytes, MSB first, into one word.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - restarts assembly at the first byte of a word
//   accept      - a byte is transferred this cycle
//   byte_in     - the transferred byte
//   word_ready  - this accepted byte completes a word
//   word_out    - the completed word (valid while word_ready is high)
// Used in turn for the header, data and checksum words.
module loader_byte_assembler
  import mips_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            byte_in,
  output logic                  word_ready,
  output logic [DATA_WIDTH-1:0] word_out
);

  localparam int BPW = int'(bytes_per_word(DATA_WIDTH));
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0] count_r;
  logic          last_byte_s;

  assign last_byte_s = (count_r == CW'(BPW - 1));
  assign word_ready  = accept && last_byte_s;

  // Byte position within the word being assembled; wraps after the last byte.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_r <= '0;
    end else if (accept) begin
      if (last_byte_s) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + CW'(1);
      end
    end
  end

  generate
    if (BPW > 1) begin : g_shift
      // Only the older bytes are stored; the current byte completes the word
      // combinationally so the top bits of the shift never need a register.
      logic [DATA_WIDTH-9:0] shift_r;

      assign word_out = {shift_r, byte_in};

      // Shift register holding bytes already received for this word.
      always_ff @(posedge clk) begin
        if (reset || clear) begin
          shift_r <= '0;
        end else if (accept) begin
          shift_r <= word_out[DATA_WIDTH-9:0];
        end
      end
    end else begin : g_single
      assign word_out = byte_in;
    end
  endgenerate

endmodule

// File: rtl/program_memory_loader.sv
// Program memory loader: receives a byte stream (header word N, then N
// big-endian words) and writes the words into instruction memory at byte
// addresses BASE_ADDRESS, +4, +8, ...
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset
//   bus    - program_memory_loader_if.slave (stream in, write port and status out)
// Parameters: MEMORY_DEPTH (max words), DATA_WIDTH (multiple of 8),
//   BASE_ADDRESS (word aligned).
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing checksum
//   word (XOR of header and data words) before a load is reported Done.
// All status/handshake outputs are registered, decoded from the next state.
module program_memory_loader
  import mips_loader_pkg::*;
#(
  parameter int unsigned           MEMORY_DEPTH = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = '0
) (
  input logic clk,
  input logic reset,
  program_memory_loader_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0] DEPTH_LIMIT = DATA_WIDTH'(MEMORY_DEPTH);
  localparam logic [DATA_WIDTH-1:0] STRIDE      = DATA_WIDTH'(ADDR_STRIDE);
  localparam logic [DATA_WIDTH-1:0] ONE         = DATA_WIDTH'(1);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e FINAL_STATE = CHECK;
`else
  localparam loader_state_e FINAL_STATE = DONE;
`endif

  loader_state_e         state_r;
  loader_state_e         next_state_s;

  logic                  byte_ready_r;
  logic                  write_enable_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  error_r;
  logic [DATA_WIDTH-1:0] write_address_r;
  logic [DATA_WIDTH-1:0] write_data_r;
  logic [DATA_WIDTH-1:0] word_count_r;
  logic [DATA_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] length_r;

  logic                  accept_s;
  logic                  start_s;
  logic                  word_ready_s;
  logic [DATA_WIDTH-1:0] word_s;

  assign accept_s = bus.ByteValid && byte_ready_r;
  // Start only counts when no load is running.
  assign start_s  = bus.Start &&
                    ((state_r == IDLE) || (state_r == DONE) || (state_r == ERROR));

  loader_byte_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_s),
    .accept     (accept_s),
    .byte_in    (bus.ByteIn),
    .word_ready (word_ready_s),
    .word_out   (word_s)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_r;

  // Running XOR of the header word and every data word of this load.
  always_ff @(posedge clk) begin
    if (reset || start_s) begin
      csum_r <= '0;
    end else if (word_ready_s && (state_r == HEADER || state_r == DATA)) begin
      csum_r <= csum_r ^ word_s;
    end
  end
`endif

  // Next-state selection for the load sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.Start) next_state_s = HEADER;
        else           next_state_s = IDLE;
      end
      HEADER: begin
        if (word_ready_s) begin
          if (word_s > DEPTH_LIMIT)  next_state_s = ERROR;
          else if (word_s == '0)     next_state_s = FINAL_STATE;
          else                       next_state_s = DATA;
        end else begin
          next_state_s = HEADER;
        end
      end
      DATA: begin
        if (word_ready_s) next_state_s = WRITE;
        else              next_state_s = DATA;
      end
      WRITE: begin
        // word_count_r still holds the count before this write completes.
        if ((word_count_r + ONE) < length_r) next_state_s = DATA;
        else                                 next_state_s = FINAL_STATE;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (word_ready_s) begin
          if (word_s == csum_r) next_state_s = DONE;
          else                  next_state_s = ERROR;
        end else begin
          next_state_s = CHECK;
        end
      end
`endif
      DONE, ERROR: begin
        if (bus.Start) next_state_s = HEADER;
        else           next_state_s = state_r;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register and status/handshake outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      byte_ready_r   <= 1'b0;
      write_enable_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      byte_ready_r   <= (next_state_s == HEADER) || (next_state_s == DATA) ||
                        (next_state_s == CHECK);
      write_enable_r <= (next_state_s == WRITE);
      busy_r         <= (next_state_s == HEADER) || (next_state_s == DATA) ||
                        (next_state_s == WRITE)  || (next_state_s == CHECK);
      done_r         <= (next_state_s == DONE);
      error_r        <= (next_state_s == ERROR);
    end
  end

  // Length, address, word counter and the held write address/data.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r          <= '0;
      length_r        <= '0;
      word_count_r    <= '0;
      write_address_r <= '0;
      write_data_r    <= '0;
    end else if (start_s) begin
      addr_r          <= BASE_ADDRESS;
      length_r        <= '0;
      word_count_r    <= '0;
    end else if (state_r == HEADER && word_ready_s) begin
      length_r        <= word_s;
    end else if (state_r == DATA && word_ready_s) begin
      // Captured on entry to WRITE and held afterwards.
      write_address_r <= addr_r;
      write_data_r    <= word_s;
    end else if (state_r == WRITE) begin
      addr_r          <= addr_r + STRIDE;
      word_count_r    <= word_count_r + ONE;
    end
  end

  assign bus.ByteReady    = byte_ready_r;
  assign bus.WriteEnable  = write_enable_r;
  assign bus.WriteAddress = write_address_r;
  assign bus.WriteData    = write_data_r;
  assign bus.Busy         = busy_r;
  assign bus.Done         = done_r;
  assign bus.Error        = error_r;
  assign bus.WordCount    = word_count_r;

endmodule
